mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM for the MIPS core. It sequences each instruction through IF/ID/EXE/MEM/WB.
//  Drives the PC register's write enable, branch select and chip enable, plus all datapath write strobes.
//  Sits between the instruction register (opcode), ALU (zero) and memories (ready handshake).
// PARAMETERS
//  OP_HALT   6'h3F  opcode that parks the core in HALT
//  ALUOP_W   3      width of alu_op
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-low
//  op         in   6        opcode from IR; stable from ID until the next IF
//  zero       in   1        ALU zero flag; valid combinationally in EXE
//  mem_ready  in   1        instr/data memory access done this cycle
//  imem_ce    out  1        instruction fetch request (PC register chip enable)
//  ir_wre     out  1        IR load strobe
//  pc_wre     out  1        PC update strobe; exactly one cycle per retired instruction
//  pc_src     out  1        1 = load branch_addr, 0 = PC+4 (valid when pc_wre=1)
//  jmp_sel    out  1        branch_addr source: 0 = PC+4+(imm<<2), 1 = jump target
//  reg_wre    out  1        register file write strobe
//  reg_dst    out  2        0 = rt, 1 = rd, 2 = $31
//  wb_sel     out  2        0 = ALU result, 1 = mem data, 2 = PC+4
//  alu_src_b  out  1        0 = rt, 1 = extended imm
//  ext_sel    out  1        0 = zero-extend, 1 = sign-extend
//  alu_op     out  ALUOP_W  0 add, 1 sub, 2 and, 3 or, 7 funct-decode
//  mem_rd     out  1        data memory read
//  mem_wr     out  1        data memory write
//  halted     out  1        FSM in HALT
//  illegal    out  1        sticky: an undecoded opcode was retired
// BEHAVIOUR
//  - States: INIT, IF, ID, EXE, MEM, WB, HALT. On rst low: state=INIT, illegal=0.
//    INIT drives every output 0, including imem_ce.
//  - INIT->IF unconditionally on the first clk after rst deasserts.
//  - Outputs are decoded combinationally from state, op, zero and mem_ready.
//    Any strobe not listed for a state is 0.
//  - IF: imem_ce=1. Hold while mem_ready=0. When mem_ready=1: ir_wre=1, go to ID.
//  - ID, by op:
//      j (02): pc_wre=1, pc_src=1, jmp_sel=1 -> IF.
//      jal (03): as j, plus reg_wre=1, reg_dst=2, wb_sel=2 -> IF.
//      OP_HALT -> HALT.
//      undecoded: pc_wre=1, pc_src=0, set illegal -> IF (retired as NOP).
//      all others -> EXE.
//  - EXE: alu_op, alu_src_b and ext_sel per op.
//      R-type (00): alu_op=7, alu_src_b=0.
//      addi (08), lw (23), sw (2B): add, imm, sign-extend.
//      ori (0D): or, imm, zero-extend.
//      beq (04)/bne (05): sub, rt. pc_wre=1, pc_src=zero (beq) or ~zero (bne), jmp_sel=0 -> IF.
//      lw/sw -> MEM. R/addi/ori -> WB.
//  - MEM: lw asserts mem_rd; sw asserts mem_wr. Hold until mem_ready=1.
//      sw: pc_wre=1, pc_src=0 in the ready cycle -> IF. lw -> WB.
//      mem_rd/mem_wr stay asserted for every held cycle.
//  - WB: reg_wre=1, pc_wre=1, pc_src=0 -> IF.
//      reg_dst=1 for R-type, else 0. wb_sel=1 for lw, else 0.
//  - HALT: terminal. All strobes 0, halted=1. Exit only through rst.
//  - Latency (mem_ready always 1): j/jal 2 cycles, branch 3, ALU 4, sw 4, lw 5.
//    Each extra wait cycle adds one.
//  - pc_wre is never asserted in IF, INIT or HALT.
//    pc_wre and ir_wre are never high in the same cycle.
//  - rst asserted mid-instruction: immediate return to INIT. No strobes in that cycle or the next.
// STRUCTURE
//  - Shared package/defines: opcode constants (OP_RTYPE ... OP_HALT), state encodings,
//    alu_op/reg_dst/wb_sel codes, and the existing RstEnable/ChipEnable macros.
//  - One sub-module, mc_ctrl_decode: pure combinational op -> class
//    (alu/load/store/branch/jump/halt/illegal) plus alu_op/ext_sel/alu_src_b.
//    The FSM and the sticky illegal flag live in mc_ctrl_fsm.
// TESTING
//  - Reset release, mem_ready=1, op=00 (R) ->
//    INIT,IF,ID,EXE,WB; pc_wre only in WB with pc_src=0; reg_wre=1, reg_dst=1.
//  - op=04, zero=1 -> pc_wre=1, pc_src=1, jmp_sel=0 in EXE.
//    Repeat with zero=0 -> pc_src=0. Repeat op=05 with the results inverted.
//  - op=23, mem_ready low 2 cycles in MEM ->
//    mem_rd high 3 cycles, then WB with wb_sel=1; total 7 cycles.
//  - op=03 -> ID asserts pc_wre, pc_src, jmp_sel, reg_wre; reg_dst=2, wb_sel=2; next state IF.
//  - op=3F -> HALT; halted=1; no pc_wre over 20 cycles; rst pulse -> INIT with imem_ce=0.
//  - op=3E -> retired in 2 cycles with pc_src=0; illegal=1 stays set until rst.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared constants and types for the multi-cycle MIPS control FSM.
// Covers opcodes, control codes, state encoding and the decoder output bundle.
package mc_ctrl_fsm_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'd7;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EXE  = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    typedef struct packed {
        op_class_e          cls;
        logic [ALUOP_W-1:0] alu_op;
        logic               ext_sel;
        logic               alu_src_b;
        logic               is_rtype;
        logic               is_link;
        logic               is_bne;
    } decode_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the sequencer and the datapath/memories.
// The master side is the control FSM; the slave side is the datapath.
interface mc_ctrl_fsm_if;
    import mc_ctrl_fsm_pkg::*;

    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               imem_ce;
    logic               ir_wre;
    logic               pc_wre;
    logic               pc_src;
    logic               jmp_sel;
    logic               reg_wre;
    logic [1:0]         reg_dst;
    logic [1:0]         wb_sel;
    logic               alu_src_b;
    logic               ext_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_rd;
    logic               mem_wr;
    logic               halted;
    logic               illegal;

    modport master (
        input  op, zero, mem_ready,
        output imem_ce, ir_wre, pc_wre, pc_src, jmp_sel, reg_wre, reg_dst, wb_sel,
               alu_src_b, ext_sel, alu_op, mem_rd, mem_wr, halted, illegal
    );

    modport slave (
        output op, zero, mem_ready,
        input  imem_ce, ir_wre, pc_wre, pc_src, jmp_sel, reg_wre, reg_dst, wb_sel,
               alu_src_b, ext_sel, alu_op, mem_rd, mem_wr, halted, illegal
    );

endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Pure combinational opcode classifier: instruction class plus the EXE-stage
// ALU controls. Anything not listed is reported as illegal.
module mc_ctrl_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0] op,
    output decode_t    dec
);

    // Opcode to class and ALU control lookup
    always_comb begin
        dec.cls       = CLS_ILLEGAL;
        dec.alu_op    = ALU_ADD;
        dec.ext_sel   = 1'b0;
        dec.alu_src_b = 1'b0;
        dec.is_rtype  = 1'b0;
        dec.is_link   = 1'b0;
        dec.is_bne    = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec.cls      = CLS_ALU;
                dec.alu_op   = ALU_FUNCT;
                dec.is_rtype = 1'b1;
            end
            OP_J:    dec.cls = CLS_JUMP;
            OP_JAL: begin
                dec.cls     = CLS_JUMP;
                dec.is_link = 1'b1;
            end
            OP_BEQ: begin
                dec.cls    = CLS_BRANCH;
                dec.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                dec.cls    = CLS_BRANCH;
                dec.alu_op = ALU_SUB;
                dec.is_bne = 1'b1;
            end
            OP_ADDI: begin
                dec.cls       = CLS_ALU;
                dec.ext_sel   = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OP_ORI: begin
                dec.cls       = CLS_ALU;
                dec.alu_op    = ALU_OR;
                dec.alu_src_b = 1'b1;
            end
            OP_LW: begin
                dec.cls       = CLS_LOAD;
                dec.ext_sel   = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OP_SW: begin
                dec.cls       = CLS_STORE;
                dec.ext_sel   = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OP_HALT: dec.cls = CLS_HALT;
            default: dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS core: walks each instruction
// through IF/ID/EXE/MEM/WB and decodes datapath strobes from the current state.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    state_e  state_r;
    state_e  state_next_s;
    decode_t dec_s;
    logic    illegal_r;
    logic    illegal_set_s;

    mc_ctrl_decode u_decode (
        .op  (bus.op),
        .dec (dec_s)
    );

    // An undecoded opcode retires from ID as a NOP and is remembered until reset
    assign illegal_set_s = (state_r == ST_ID) && (dec_s.cls == CLS_ILLEGAL);
    assign bus.illegal   = illegal_r;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            illegal_r <= 1'b0;
        end else if (illegal_set_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: state_next_s = ST_IF;
            ST_IF:   state_next_s = bus.mem_ready ? ST_ID : ST_IF;
            ST_ID: begin
                case (dec_s.cls)
                    CLS_JUMP, CLS_ILLEGAL: state_next_s = ST_IF;
                    CLS_HALT:              state_next_s = ST_HALT;
                    default:               state_next_s = ST_EXE;
                endcase
            end
            ST_EXE: begin
                case (dec_s.cls)
                    CLS_BRANCH:          state_next_s = ST_IF;
                    CLS_LOAD, CLS_STORE: state_next_s = ST_MEM;
                    CLS_ALU:             state_next_s = ST_WB;
                    default:             state_next_s = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (!bus.mem_ready) begin
                    state_next_s = ST_MEM;
                end else if (dec_s.cls == CLS_STORE) begin
                    state_next_s = ST_IF;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_WB:   state_next_s = ST_IF;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_INIT;
        endcase
    end

    // Output decode; ALU controls are only driven while the ALU is in use
    always_comb begin
        bus.imem_ce   = CHIP_DISABLE;
        bus.ir_wre    = 1'b0;
        bus.pc_wre    = 1'b0;
        bus.pc_src    = 1'b0;
        bus.jmp_sel   = 1'b0;
        bus.reg_wre   = 1'b0;
        bus.reg_dst   = REG_DST_RT;
        bus.wb_sel    = WB_ALU;
        bus.alu_src_b = 1'b0;
        bus.ext_sel   = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.halted    = 1'b0;
        case (state_r)
            ST_IF: begin
                bus.imem_ce = CHIP_ENABLE;
                bus.ir_wre  = bus.mem_ready;
            end
            ST_ID: begin
                case (dec_s.cls)
                    CLS_JUMP: begin
                        bus.pc_wre  = 1'b1;
                        bus.pc_src  = 1'b1;
                        bus.jmp_sel = 1'b1;
                        if (dec_s.is_link) begin
                            bus.reg_wre = 1'b1;
                            bus.reg_dst = REG_DST_RA;
                            bus.wb_sel  = WB_PC4;
                        end else begin
                            bus.reg_wre = 1'b0;
                        end
                    end
                    CLS_ILLEGAL: bus.pc_wre = 1'b1;
                    default:     bus.pc_wre = 1'b0;
                endcase
            end
            ST_EXE: begin
                bus.alu_op    = dec_s.alu_op;
                bus.alu_src_b = dec_s.alu_src_b;
                bus.ext_sel   = dec_s.ext_sel;
                if (dec_s.cls == CLS_BRANCH) begin
                    bus.pc_wre = 1'b1;
                    bus.pc_src = dec_s.is_bne ? ~bus.zero : bus.zero;
                end else begin
                    bus.pc_wre = 1'b0;
                end
            end
            ST_MEM: begin
                bus.mem_rd = (dec_s.cls == CLS_LOAD);
                bus.mem_wr = (dec_s.cls == CLS_STORE);
                bus.pc_wre = (dec_s.cls == CLS_STORE) && bus.mem_ready;
            end
            ST_WB: begin
                bus.reg_wre = 1'b1;
                bus.pc_wre  = 1'b1;
                bus.reg_dst = dec_s.is_rtype ? REG_DST_RD : REG_DST_RT;
                bus.wb_sel  = (dec_s.cls == CLS_LOAD) ? WB_MEM : WB_ALU;
            end
            ST_HALT: bus.halted = 1'b1;
            ST_INIT: bus.halted = 1'b0;
            default: bus.halted = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized self-checking bench for mc_ctrl_fsm: each instruction is expanded
// into its expected per-cycle control trace and compared cycle by cycle.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       imem_ce;
        logic       ir_wre;
        logic       pc_wre;
        logic       pc_src;
        logic       jmp_sel;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src_b;
        logic       ext_sel;
        logic [2:0] alu_op;
        logic       mem_rd;
        logic       mem_wr;
        logic       halted;
    } ctl_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic ill_model;

    logic [5:0] legal_ops [9] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {bus.imem_ce, bus.ir_wre, bus.pc_wre, bus.pc_src, bus.jmp_sel, bus.reg_wre,
                bus.reg_dst, bus.wb_sel, bus.alu_src_b, bus.ext_sel, bus.alu_op,
                bus.mem_rd, bus.mem_wr, bus.halted, bus.illegal};
    endfunction

    function automatic bit is_known(input logic [5:0] o);
        case (o)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h3F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Assert reset just after an edge, check outputs are quiet, release, check the idle cycle
    task automatic apply_reset(input int hold);
        ctl_t quiet;
        quiet = '0;
        rst = 1'b0;
        #1;
        ill_model = 1'b0;
        check_eq("rst_async", 32'(dut_vec()), 32'({quiet, ill_model}));
        repeat (hold) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold", 32'(dut_vec()), 32'({quiet, ill_model}));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_init", 32'(dut_vec()), 32'({quiet, ill_model}));
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its expected control trace, then drive and compare it
    task automatic run_instr(input logic [5:0] o, input logic z, input int if_wait, input int mem_wait);
        ctl_t eq [$];
        logic rq [$];
        ctl_t c;
        logic mark_ill;
        mark_ill = 1'b0;
        for (int i = 0; i < if_wait; i++) begin
            c = '0;
            c.imem_ce = 1'b1;
            eq.push_back(c);
            rq.push_back(1'b0);
        end
        c = '0;
        c.imem_ce = 1'b1;
        c.ir_wre  = 1'b1;
        eq.push_back(c);
        rq.push_back(1'b1);
        c = '0;
        if (o == 6'h02 || o == 6'h03) begin
            c.pc_wre  = 1'b1;
            c.pc_src  = 1'b1;
            c.jmp_sel = 1'b1;
            if (o == 6'h03) begin
                c.reg_wre = 1'b1;
                c.reg_dst = 2'd2;
                c.wb_sel  = 2'd2;
            end
            eq.push_back(c);
            rq.push_back(rnd_bit());
        end else if (!is_known(o)) begin
            c.pc_wre = 1'b1;
            eq.push_back(c);
            rq.push_back(rnd_bit());
            mark_ill = 1'b1;
        end else if (o == 6'h3F) begin
            eq.push_back(c);
            rq.push_back(rnd_bit());
        end else begin
            eq.push_back(c);
            rq.push_back(rnd_bit());
            c = '0;
            case (o)
                6'h00: c.alu_op = 3'd7;
                6'h0D: begin
                    c.alu_op    = 3'd3;
                    c.alu_src_b = 1'b1;
                end
                6'h04, 6'h05: begin
                    c.alu_op = 3'd1;
                    c.pc_wre = 1'b1;
                    c.pc_src = (o == 6'h04) ? z : ~z;
                end
                default: begin
                    c.alu_op    = 3'd0;
                    c.alu_src_b = 1'b1;
                    c.ext_sel   = 1'b1;
                end
            endcase
            eq.push_back(c);
            rq.push_back(rnd_bit());
            if (o == 6'h23 || o == 6'h2B) begin
                for (int w = 0; w <= mem_wait; w++) begin
                    c = '0;
                    c.mem_rd = (o == 6'h23);
                    c.mem_wr = (o == 6'h2B);
                    c.pc_wre = (o == 6'h2B) && (w == mem_wait);
                    eq.push_back(c);
                    rq.push_back(w == mem_wait);
                end
            end
            if (o != 6'h04 && o != 6'h05 && o != 6'h2B) begin
                c = '0;
                c.reg_wre = 1'b1;
                c.pc_wre  = 1'b1;
                c.reg_dst = (o == 6'h00) ? 2'd1 : 2'd0;
                c.wb_sel  = (o == 6'h23) ? 2'd1 : 2'd0;
                eq.push_back(c);
                rq.push_back(rnd_bit());
            end
        end
        foreach (eq[i]) begin
            bus.op        = o;
            bus.zero      = z;
            bus.mem_ready = rq[i];
            @(negedge clk);
            check_eq($sformatf("op%02h_cyc%0d", o, i), 32'(dut_vec()), 32'({eq[i], ill_model}));
            @(posedge clk);
            #1;
        end
        if (mark_ill) ill_model = 1'b1;
    endtask

    // HALT must ignore every input and never move the PC
    task automatic run_halted(input int n);
        ctl_t c;
        c = '0;
        c.halted = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.op        = 6'($urandom);
            bus.zero      = rnd_bit();
            bus.mem_ready = rnd_bit();
            @(negedge clk);
            check_eq($sformatf("halt_cyc%0d", i), 32'(dut_vec()), 32'({c, ill_model}));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] rop;
        n_checks      = 0;
        n_fail        = 0;
        ill_model     = 1'b0;
        rst           = 1'b1;
        bus.op        = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        apply_reset(2);

        run_instr(6'h00, 1'b0, 0, 0);
        run_instr(6'h04, 1'b1, 0, 0);
        run_instr(6'h04, 1'b0, 0, 0);
        run_instr(6'h05, 1'b1, 0, 0);
        run_instr(6'h05, 1'b0, 0, 0);
        run_instr(6'h23, 1'b0, 0, 2);
        run_instr(6'h03, 1'b0, 0, 0);
        run_instr(6'h2B, 1'b1, 1, 1);
        run_instr(6'h08, 1'b0, 2, 0);
        run_instr(6'h0D, 1'b1, 0, 0);
        run_instr(6'h02, 1'b0, 0, 0);
        run_instr(6'h3E, 1'b0, 0, 0);
        run_instr(6'h00, 1'b0, 0, 0);
        run_instr(6'h23, 1'b0, 1, 0);
        check_eq("illegal_sticky", 32'(bus.illegal), 32'(1'b1));

        // Reset while a load sits in MEM with mem_rd asserted
        bus.op        = 6'h23;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        apply_reset(1);
        run_instr(6'h00, 1'b0, 0, 0);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(9, 0) == 0) begin
                rop = 6'($urandom);
                if (is_known(rop)) rop = 6'h3E;
            end else begin
                rop = legal_ops[$urandom_range(8, 0)];
            end
            run_instr(rop, rnd_bit(), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
        end

        run_instr(6'h3F, 1'b0, 1, 0);
        run_halted(20);
        apply_reset(1);
        run_instr(6'h00, 1'b0, 0, 0);
        run_instr(6'h2B, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
